fetch_predict_unit: RTL

//  Parametrised fetch stage for the 5-stage pipeline: owns the PC and drives imemaddr/imemREN.

---
 rtl/fetch_predict_if.sv | 47 ++++
 rtl/fetch_predict_unit.sv | 127 ++++++++++++
 2 files changed

// File: rtl/fetch_predict_if.sv
// Fetch/predict bundle between the fetch stage and the rest of the datapath.
//   master : fetch stage (drives PC, prediction, flush and perf counts)
//   slave  : datapath / cache side (drives ihit, stall, halt and MEM-stage resolution)
// Signals:
//   ihit, stall, halt                 fetch control from datapath
//   imemaddr, imemREN                 instruction fetch request
//   pred_taken, pred_target           prediction for the current PC
//   res_*                             branch/jump resolution from MEM
//   flush                             squash IF/ID and ID/EX
//   branch_cnt, mispred_cnt           saturating performance counters
interface fetch_predict_if #(
    parameter int unsigned PERF_W = 16
);
    logic              ihit;
    logic              stall;
    logic              halt;
    logic [31:0]       imemaddr;
    logic              imemREN;
    logic              pred_taken;
    logic [31:0]       pred_target;
    logic              res_valid;
    logic [31:0]       res_pc;
    logic              res_is_branch;
    logic              res_taken;
    logic [31:0]       res_target;
    logic              res_pred_taken;
    logic [31:0]       res_pred_target;
    logic              flush;
    logic [PERF_W-1:0] branch_cnt;
    logic [PERF_W-1:0] mispred_cnt;

    modport master (
        input  ihit, stall, halt,
        input  res_valid, res_pc, res_is_branch, res_taken, res_target,
        input  res_pred_taken, res_pred_target,
        output imemaddr, imemREN, pred_taken, pred_target, flush,
        output branch_cnt, mispred_cnt
    );

    modport slave (
        output ihit, stall, halt,
        output res_valid, res_pc, res_is_branch, res_taken, res_target,
        output res_pred_taken, res_pred_target,
        input  imemaddr, imemREN, pred_taken, pred_target, flush,
        input  branch_cnt, mispred_cnt
    );
endinterface

// File: rtl/fetch_predict_unit.sv
// Fetch stage with a direct-mapped BTB of 2-bit saturating counters.
// Owns the PC, predicts the next PC combinationally from the current PC, applies
// MEM-stage redirects, and counts resolved branches and mispredicts.
// Ports:
//   CLK   clock
//   nRST  asynchronous reset, active low
//   fif   fetch_predict_if.master (fetch control, prediction, resolution, perf)
module fetch_predict_unit #(
    parameter logic [31:0] PC_INIT     = 32'h0,
    parameter int unsigned BTB_ENTRIES = 16,
    parameter logic [1:0]  CTR_INIT    = 2'b10,
    parameter int unsigned PERF_W      = 16
) (
    input  logic            CLK,
    input  logic            nRST,
    fetch_predict_if.master fif
);
    localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = 32 - IDX_W - 2;

    logic [31:0]       pc_q, pc_d, pc_plus4;
    logic              halt_q;
    logic [PERF_W-1:0] branch_cnt_q, mispred_cnt_q;

    logic              btb_valid_q [BTB_ENTRIES];
    logic [TAG_W-1:0]  btb_tag_q   [BTB_ENTRIES];
    logic [31:0]       btb_tgt_q   [BTB_ENTRIES];
    logic [1:0]        btb_ctr_q   [BTB_ENTRIES];

    logic [IDX_W-1:0]  lk_idx, up_idx;
    logic [TAG_W-1:0]  lk_tag, up_tag;
    logic              lk_hit, up_hit, up_en, res_br, mis;
    logic              pred_taken;
    logic [31:0]       pred_target, fix_pc;

    // Lookup on the current PC
    assign pc_plus4    = pc_q + 32'd4;
    assign lk_idx      = pc_q[IDX_W+1:2];
    assign lk_tag      = pc_q[31:IDX_W+2];
    assign lk_hit      = btb_valid_q[lk_idx] && (btb_tag_q[lk_idx] == lk_tag);
    assign pred_taken  = lk_hit && btb_ctr_q[lk_idx][1];
    assign pred_target = lk_hit ? btb_tgt_q[lk_idx] : pc_plus4;

    // Resolution from MEM; a predicted-taken non-branch is caught by the first term
    assign mis = fif.res_valid &&
                 ((fif.res_taken != fif.res_pred_taken) ||
                  (fif.res_taken && (fif.res_target != fif.res_pred_target)));
    assign fix_pc = fif.res_taken ? fif.res_target : (fif.res_pc + 32'd4);

    assign res_br = fif.res_valid && fif.res_is_branch;
    assign up_en  = res_br && !halt_q;
    assign up_idx = fif.res_pc[IDX_W+1:2];
    assign up_tag = fif.res_pc[31:IDX_W+2];
    assign up_hit = btb_valid_q[up_idx] && (btb_tag_q[up_idx] == up_tag);

    always_comb begin
        pc_d = pc_q;
        if (halt_q) begin
            pc_d = pc_q;
        end else if (mis) begin
            pc_d = fix_pc;
        end else if (fif.ihit && !fif.stall) begin
            pc_d = pred_taken ? pred_target : pc_plus4;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pc_q   <= PC_INIT;
            halt_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            halt_q <= halt_q | fif.halt;
        end
    end

    // BTB write lands at the edge, so a same-cycle lookup still sees the old entry
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
                btb_valid_q[i] <= 1'b0;
                btb_tag_q[i]   <= '0;
                btb_tgt_q[i]   <= '0;
                btb_ctr_q[i]   <= 2'b00;
            end
        end else if (up_en) begin
            if (up_hit) begin
                if (fif.res_taken) begin
                    btb_tgt_q[up_idx] <= fif.res_target;
                    if (btb_ctr_q[up_idx] != 2'b11) begin
                        btb_ctr_q[up_idx] <= btb_ctr_q[up_idx] + 2'b01;
                    end
                end else if (btb_ctr_q[up_idx] != 2'b00) begin
                    btb_ctr_q[up_idx] <= btb_ctr_q[up_idx] - 2'b01;
                end
            end else if (fif.res_taken) begin
                btb_valid_q[up_idx] <= 1'b1;
                btb_tag_q[up_idx]   <= up_tag;
                btb_tgt_q[up_idx]   <= fif.res_target;
                btb_ctr_q[up_idx]   <= CTR_INIT;
            end
        end
    end

    // Perf counters keep counting after halt and stick at all-ones
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (res_br && (branch_cnt_q != '1)) begin
                branch_cnt_q <= branch_cnt_q + 1'b1;
            end
            if (mis && (mispred_cnt_q != '1)) begin
                mispred_cnt_q <= mispred_cnt_q + 1'b1;
            end
        end
    end

    assign fif.imemaddr    = pc_q;
    assign fif.imemREN     = !halt_q;
    assign fif.pred_taken  = pred_taken;
    assign fif.pred_target = pred_target;
    assign fif.flush       = mis && !halt_q;
    assign fif.branch_cnt  = branch_cnt_q;
    assign fif.mispred_cnt = mispred_cnt_q;
endmodule
